// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the dmem_arbiter and its two requesters
// (pipeline MEM stage and loader/debug port).
interface dmem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    // Pipeline side: p_req is held while p_stall is high; the access is
    // performed in any cycle with p_req=1 and p_stall=0 (flush cancels it).
    // Loader side: l_req is held until l_gnt; the access is performed in the
    // l_gnt cycle. Read data returns with *_rvalid one cycle later.
    logic              p_req;
    logic              p_we;
    logic [DATA_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              flush;
    logic              p_stall;
    logic              p_rvalid;
    logic [DATA_W-1:0] p_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, flush,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        output p_stall, p_rvalid, p_rdata,
        output l_gnt, l_rvalid, l_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, flush,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        input  p_stall, p_rvalid, p_rdata,
        input  l_gnt, l_rvalid, l_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port 64-word data memory shared between the pipeline (priority)
// and a loader port, with starvation-forced loader slots and a lock mode.
module dmem_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic [0:0]    o_dbg_state,
    output logic [3:0]    o_dbg_wait_cnt
);
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [0:0] S_PIPE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

    logic [0:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_p_rvalid;
    logic [DATA_W-1:0] r_p_rdata;
    logic              r_l_rvalid;
    logic [DATA_W-1:0] r_l_rdata;

    logic              w_p_acc;
    logic              w_l_gnt;
    logic              w_p_stall;
    logic [3:0]        w_wait_nxt;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_acc_wr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused;

    // Upper pipeline address bits are ignored: addresses wrap modulo DEPTH.
    assign w_unused = ^bus.p_addr[DATA_W-1:ADDR_W];

    // Arbitration: forced loader slot, then pipeline, then loader.
    always_comb begin
        w_p_acc   = 1'b0;
        w_l_gnt   = 1'b0;
        w_p_stall = 1'b0;
        if (rst) begin
            if (r_state == S_LOCK) begin
                w_p_stall = bus.p_req;
                w_l_gnt   = bus.l_req;
            end else if ((r_wait_cnt == LIMIT) && bus.l_req) begin
                w_l_gnt   = 1'b1;
                w_p_stall = bus.p_req;
            end else if (bus.p_req && !bus.flush) begin
                w_p_acc   = 1'b1;
            end else if (bus.l_req) begin
                w_l_gnt   = 1'b1;
            end
        end
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (r_state == S_LOCK || w_l_gnt || !bus.l_req) begin
            w_wait_nxt = 4'd0;
        end else if (r_wait_cnt < LIMIT) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end
    end

    // At most one of w_p_acc / w_l_gnt is set, so one shared access port.
    assign w_acc_addr  = w_p_acc ? bus.p_addr[ADDR_W-1:0] : bus.l_addr;
    assign w_acc_wr    = (w_p_acc && bus.p_we) || (w_l_gnt && bus.l_we);
    assign w_acc_wdata = w_p_acc ? bus.p_wdata : bus.l_wdata;
    assign w_rd_word   = r_mem[w_acc_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_PIPE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= bus.l_lock ? S_LOCK : S_PIPE;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_acc_wr) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_rvalid <= 1'b0;
            r_p_rdata  <= '0;
            r_l_rvalid <= 1'b0;
            r_l_rdata  <= '0;
        end else begin
            r_p_rvalid <= w_p_acc && !bus.p_we;
            r_l_rvalid <= w_l_gnt && !bus.l_we;
            if (w_p_acc && !bus.p_we) begin
                r_p_rdata <= w_rd_word;
            end
            if (w_l_gnt && !bus.l_we) begin
                r_l_rdata <= w_rd_word;
            end
        end
    end

    // A flush in the response cycle cancels the in-flight pipeline read.
    assign bus.p_rvalid = r_p_rvalid && !bus.flush;
    assign bus.p_rdata  = r_p_rdata;
    assign bus.p_stall  = w_p_stall;
    assign bus.l_gnt    = w_l_gnt;
    assign bus.l_rvalid = r_l_rvalid;
    assign bus.l_rdata  = r_l_rdata;

    assign o_dbg_state    = r_state;
    assign o_dbg_wait_cnt = r_wait_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter.
module tb_dmem_arbiter;
    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 6;
    localparam int STARVE_LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] dbg_state;
    logic [3:0] dbg_wait;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_dbg_state(dbg_state),
        .o_dbg_wait_cnt(dbg_wait)
    );

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] p_exp_q[$];
    logic [DATA_W-1:0] l_exp_q[$];
    logic [DATA_W-1:0] e_p;
    logic [DATA_W-1:0] e_l;
    logic [DATA_W-1:0] lock_vals [3] = '{16'd10, 16'd6, 16'd4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected word per presented response.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.p_rvalid === 1'b1) begin
                if (p_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL p_rvalid_unexpected: got rdata %0d expected no response", bus.p_rdata);
                end else begin
                    e_p = p_exp_q.pop_front();
                    check("p_rdata", bus.p_rdata, e_p);
                end
            end
            if (bus.l_rvalid === 1'b1) begin
                if (l_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL l_rvalid_unexpected: got rdata %0d expected no response", bus.l_rdata);
                end else begin
                    e_l = l_exp_q.pop_front();
                    check("l_rdata", bus.l_rdata, e_l);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.flush = 1'b0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
        bus.l_lock = 1'b0;
    endtask

    // Called at posedge+1; performs one pipeline access in that cycle.
    task automatic p_op(input logic we, input logic [DATA_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp);
        bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = addr; bus.p_wdata = wdata;
        @(negedge clk);
        check("p_op_stall", bus.p_stall, 0);
        if (!we) p_exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.p_req = 1'b0; bus.p_we = 1'b0;
    endtask

    task automatic l_op(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp);
        bit got;
        got = 1'b0;
        bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.l_gnt === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("l_gnt_timeout", got, 1);
        if (got && !we) l_exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.l_req = 1'b0; bus.l_we = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        bus.p_req = 1'b1; bus.l_req = 1'b1; bus.l_lock = 1'b1;
        #1;
        check("rst_p_stall", bus.p_stall, 0);
        check("rst_l_gnt", bus.l_gnt, 0);
        check("rst_p_rvalid", bus.p_rvalid, 0);
        check("rst_p_rdata", bus.p_rdata, 0);
        check("rst_l_rvalid", bus.l_rvalid, 0);
        check("rst_l_rdata", bus.l_rdata, 0);
        check("rst_state", dbg_state, 0);
        check("rst_wait_cnt", dbg_wait, 0);
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic write/read, all other words zero.
        p_op(1'b1, 16'd0, 16'd30000, 16'd0);
        p_op(1'b0, 16'd0, 16'd0, 16'd30000);
        for (int a = 1; a < 64; a++) p_op(1'b0, 16'(a), 16'd0, 16'd0);

        // Starvation: forced loader slot in cycle STARVE_LIMIT.
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 16'd0;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 6'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("starve_wait_cnt", dbg_wait, (c == 5) ? 0 : c);
            check("starve_l_gnt", bus.l_gnt, (c == 4) ? 1 : 0);
            check("starve_p_stall", bus.p_stall, (c == 4) ? 1 : 0);
            if (c == 4) l_exp_q.push_back(16'd30000);
            else p_exp_q.push_back(16'd30000);
            @(posedge clk); #1;
            if (c == 4) bus.l_req = 1'b0;
        end
        bus.p_req = 1'b0;

        // Lock: loader burst while the pipeline is held off.
        bus.l_lock = 1'b1;
        @(negedge clk);
        check("lock_entry_state", dbg_state, 0);
        @(posedge clk); #1;
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 16'd2;
        for (int i = 0; i < 3; i++) begin
            bus.l_req = 1'b1; bus.l_we = 1'b1;
            bus.l_addr = 6'(i + 1); bus.l_wdata = lock_vals[i];
            @(negedge clk);
            check("lock_state", dbg_state, 1);
            check("lock_p_stall", bus.p_stall, 1);
            check("lock_l_gnt", bus.l_gnt, 1);
            check("lock_wait_cnt", dbg_wait, 0);
            @(posedge clk); #1;
        end
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
        @(negedge clk);
        check("lock_exit_p_stall", bus.p_stall, 1);
        @(posedge clk); #1;
        p_op(1'b0, 16'd2, 16'd0, 16'd6);
        check("unlock_state", dbg_state, 0);
        l_op(1'b0, 6'd3, 16'd0, 16'd4);
        p_op(1'b0, 16'd1, 16'd0, 16'd10);

        // Flush cancels an in-flight read and a same-cycle write.
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 16'd5;
        @(negedge clk);
        check("flush_rd_stall", bus.p_stall, 0);
        @(posedge clk); #1;
        bus.p_req = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        check("flush_cancel_rvalid", bus.p_rvalid, 0);
        @(posedge clk); #1;
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 16'd5; bus.p_wdata = 16'd1234;
        @(negedge clk);
        check("flush_wr_stall", bus.p_stall, 0);
        @(posedge clk); #1;
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.flush = 1'b0;
        p_op(1'b0, 16'd5, 16'd0, 16'd0);

        // Address wrap: 70 maps to word 6.
        p_op(1'b1, 16'd70, 16'd100, 16'd0);
        l_op(1'b0, 6'd6, 16'd0, 16'd100);
        p_op(1'b0, 16'd6, 16'd0, 16'd100);

        // Reset mid-lock with a loader read response pending.
        bus.l_lock = 1'b1;
        @(posedge clk); #1;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 6'd1;
        bus.p_req = 1'b1; bus.p_addr = 16'd0;
        @(negedge clk);
        check("midlock_l_gnt", bus.l_gnt, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.l_req = 1'b0; bus.l_lock = 1'b0;
        #1;
        check("midlock_rst_l_rvalid", bus.l_rvalid, 0);
        check("midlock_rst_l_rdata", bus.l_rdata, 0);
        check("midlock_rst_p_rdata", bus.p_rdata, 0);
        check("midlock_rst_state", dbg_state, 0);
        check("midlock_rst_p_stall", bus.p_stall, 0);
        bus.p_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        p_op(1'b0, 16'd0, 16'd0, 16'd0);
        p_op(1'b0, 16'd1, 16'd0, 16'd0);
        p_op(1'b0, 16'd2, 16'd0, 16'd0);
        l_op(1'b0, 6'd6, 16'd0, 16'd0);

        repeat (3) begin @(posedge clk); #1; end
        check("queues_drained", p_exp_q.size() + l_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
